// File: rtl/rgb_gray_loader_pkg.sv
// Shared definitions for the RGB444-to-gray loader and the downstream edge processor:
// pixel field layout, conversion modes, luma weights and frame geometry.
package rgb_gray_loader_pkg;

   localparam int PIX_W     = 12;
   localparam int CHAN_W    = 4;
   localparam int PIX_R_LSB = 8;
   localparam int PIX_G_LSB = 4;
   localparam int PIX_B_LSB = 0;

   typedef enum logic [1:0] {
      CMD_WEIGHTED = 2'b00,
      CMD_AVG      = 2'b01,
      CMD_MAX      = 2'b10,
      CMD_BYPASS   = 2'b11
   } cmd_e;

   // 5/9/2 sums to 16, so the weighted luma is a plain 4-bit right shift
   localparam logic [7:0] LUMA_W_R = 8'd5;
   localparam logic [7:0] LUMA_W_G = 8'd9;
   localparam logic [7:0] LUMA_W_B = 8'd2;

   localparam int FRAME_WIDTH  = 400;
   localparam int FRAME_HEIGHT = 300;
   localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      DRAIN = 2'b10,
      DONE  = 2'b11
   } state_e;

   function automatic logic [CHAN_W-1:0] max3(input logic [CHAN_W-1:0] a,
                                              input logic [CHAN_W-1:0] b,
                                              input logic [CHAN_W-1:0] c);
      logic [CHAN_W-1:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rgb_gray_loader_luma.sv
// Combinational RGB444 to replicated-luma converter; bypass mode passes the pixel through.
module rgb444_to_luma
   import rgb_gray_loader_pkg::*;
#(
   parameter int DATA_WIDTH = PIX_W
) (
   input  logic [DATA_WIDTH-1:0] i_pixel,
   input  cmd_e                  i_mode,
   output logic [DATA_WIDTH-1:0] o_word
);

   logic [CHAN_W-1:0] w_r;
   logic [CHAN_W-1:0] w_g;
   logic [CHAN_W-1:0] w_b;
   logic [7:0]        w_weighted;
   logic [7:0]        w_avg;
   logic [CHAN_W-1:0] w_y;

   assign w_r = i_pixel[PIX_R_LSB +: CHAN_W];
   assign w_g = i_pixel[PIX_G_LSB +: CHAN_W];
   assign w_b = i_pixel[PIX_B_LSB +: CHAN_W];

   // Both sums stay below 256, so 8 bits never overflow
   assign w_weighted = LUMA_W_R * {4'd0, w_r} + LUMA_W_G * {4'd0, w_g} + LUMA_W_B * {4'd0, w_b};
   assign w_avg      = {4'd0, w_r} + {3'd0, w_g, 1'b0} + {4'd0, w_b};

   always_comb begin
      w_y    = '0;
      o_word = DATA_WIDTH'({3{w_y}});
      case (i_mode)
         CMD_WEIGHTED: w_y = 4'(w_weighted >> 4);
         CMD_AVG:      w_y = 4'(w_avg >> 2);
         CMD_MAX:      w_y = max3(w_r, w_g, w_b);
         default:      w_y = '0;
      endcase
      o_word = (i_mode == CMD_BYPASS) ? i_pixel : DATA_WIDTH'({3{w_y}});
   end

endmodule

// File: rtl/rgb_gray_loader.sv
// Streams one frame from the source BRAM through the luma converter into the gray BRAM.
// Read address and write address are kept in lock-step through a valid/address pipeline.
module rgb_gray_loader
   import rgb_gray_loader_pkg::*;
#(
   parameter int DATA_WIDTH  = 12,
   parameter int ADDR_WIDTH  = 19,
   parameter int DATA_LENGTH = FRAME_PIXELS,
   parameter int RD_LATENCY  = 1
) (
   input  logic                  clk_p,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            cmd,
   output logic [ADDR_WIDTH-1:0] r_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  write_en,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_LENGTH - 1);

   state_e                r_state;
   state_e                w_nextState;
   cmd_e                  r_mode;
   logic [RD_LATENCY-1:0] r_vldPipe;
   logic [ADDR_WIDTH-1:0] r_addrPipe [RD_LATENCY];
   logic                  w_startOk;
   logic                  w_issue;
   logic                  w_lastWrite;
   logic [DATA_WIDTH-1:0] w_word;

   rgb444_to_luma #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_luma (
      .i_pixel (data_in),
      .i_mode  (r_mode),
      .o_word  (w_word)
   );

   always_comb begin
      w_nextState = r_state;
      w_startOk   = 1'b0;
      w_issue     = 1'b0;
      w_lastWrite = write_en && (w_addr == LAST_ADDR);
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_startOk   = 1'b1;
               w_nextState = READ;
            end
         end
         READ: begin
            w_issue = 1'b1;
            if (r_addr == LAST_ADDR) w_nextState = DRAIN;
         end
         DRAIN: begin
            if (w_lastWrite) w_nextState = DONE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   assign busy = (r_state == READ) || (r_state == DRAIN);
   assign done = (r_state == DONE);

   // Stage RD_LATENCY-1 lines up with data_in, so the output register lands one cycle later
   always_ff @(posedge clk_p) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mode    <= CMD_WEIGHTED;
         r_addr    <= '0;
         r_vldPipe <= '0;
         for (int i = 0; i < RD_LATENCY; i++) r_addrPipe[i] <= '0;
         w_addr    <= '0;
         data_out  <= '0;
         write_en  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_startOk) begin
            r_mode <= cmd_e'(cmd);
            r_addr <= '0;
         end else if (w_issue && (r_addr != LAST_ADDR)) begin
            r_addr <= r_addr + 1'b1;
         end
         r_vldPipe[0]  <= w_issue;
         r_addrPipe[0] <= r_addr;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_vldPipe[i]  <= r_vldPipe[i-1];
            r_addrPipe[i] <= r_addrPipe[i-1];
         end
         write_en <= r_vldPipe[RD_LATENCY-1];
         if (r_vldPipe[RD_LATENCY-1]) begin
            w_addr   <= r_addrPipe[RD_LATENCY-1];
            data_out <= w_word;
         end
      end
   end

endmodule
